aes_round_ctrl: RTL

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_pkg.sv | 67 ++++++
 rtl/aes_round.sv | 16 +
 rtl/aes_round_ctrl.sv | 96 +++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, round-count constants and the byte-level round transforms.
package aes_pkg;

    typedef logic [0:127] aesState_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrlState_e;

    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    // Forward S-box, entry 0 in the leftmost byte.
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic aesState_t sub_bytes(input aesState_t s);
        aesState_t o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    // Byte index is row + 4*column; row r rotates left by r columns.
    function automatic aesState_t shift_rows(input aesState_t s);
        aesState_t o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[8*(r + 4*c) +: 8] = s[8*(r + 4*((c + r) % 4)) +: 8];
        return o;
    endfunction

    function automatic aesState_t mix_columns(input aesState_t s);
        aesState_t o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c      +: 8];
            a1 = s[32*c + 8  +: 8];
            a2 = s[32*c + 16 +: 8];
            a3 = s[32*c + 24 +: 8];
            o[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES encryption round; iFinal drops MixColumns for the last round.
module aes_round
    import aes_pkg::*;
(
    input  logic [0:127] iState,
    input  logic [0:127] iRoundKey,
    input  logic         iFinal,
    output logic [0:127] oState
);

    aesState_t shifted;

    assign shifted = shift_rows(sub_bytes(iState));
    assign oState  = (iFinal ? shifted : mix_columns(shifted)) ^ iRoundKey;

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption controller: one round per clock, round keys fetched by index.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for iValid; initial AddRoundKey on accept
//   RUN   | applying round roundCnt (1..NR) with key oRoundIdx
//   DONE  | ciphertext held on oData until iReady
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR = NR_128
) (
    input  logic         iClk,
    input  logic         iRstn,
    input  logic         iValid,
    output logic         oReady,
    input  logic [0:127] iData,
    output logic [3:0]   oRoundIdx,
    input  logic [0:127] iRoundKey,
    output logic         oValid,
    input  logic         iReady,
    output logic [0:127] oData,
    output logic         oBusy
);

    localparam logic [3:0] NR_LAST = 4'(NR);

    ctrlState_e fsm, fsmNext;
    logic [3:0] roundCnt, roundCntNext;
    aesState_t  stateReg, stateNext, roundOut;
    logic       lastRound;

    // Compare with >= so a corrupted counter still terminates the block.
    assign lastRound = (fsm == RUN) && (roundCnt >= NR_LAST);

    aes_round uRound (
        .iState   (stateReg),
        .iRoundKey(iRoundKey),
        .iFinal   (lastRound),
        .oState   (roundOut)
    );

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            fsm      <= IDLE;
            roundCnt <= 4'd0;
            stateReg <= '0;
        end else begin
            fsm      <= fsmNext;
            roundCnt <= roundCntNext;
            stateReg <= stateNext;
        end
    end

    always_comb begin
        fsmNext      = fsm;
        roundCntNext = roundCnt;
        stateNext    = stateReg;
        oReady       = 1'b0;
        oValid       = 1'b0;
        oBusy        = 1'b1;
        oRoundIdx    = 4'd0;
        case (fsm)
            IDLE: begin
                oReady = 1'b1;
                oBusy  = 1'b0;
                if (iValid) begin
                    stateNext    = iData ^ iRoundKey;
                    roundCntNext = 4'd1;
                    fsmNext      = RUN;
                end
            end
            RUN: begin
                oRoundIdx = roundCnt;
                stateNext = roundOut;
                if (lastRound) begin
                    roundCntNext = 4'd0;
                    fsmNext      = DONE;
                end else begin
                    roundCntNext = roundCnt + 4'd1;
                end
            end
            DONE: begin
                oValid = 1'b1;
                if (iReady) fsmNext = IDLE;
            end
            default: begin
                roundCntNext = 4'd0;
                fsmNext      = IDLE;
            end
        endcase
    end

    assign oData = stateReg;

endmodule
